noc_vc_input_port: RTL

NOC_VC_INPUT_PORT -- requirements
Module: noc_vc_input_port

---
 rtl/noc_pkg.sv | 13 +
 rtl/noc_rr_arbiter.sv | 45 ++++
 rtl/noc_vc_input_port.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/noc_pkg.sv
// noc_pkg: shared defaults for the NoC virtual-channel input port.
//   NOC_DATA_W / NOC_DEPTH / NOC_NUM_VC : default flit width, per-VC depth,
//                                         number of virtual channels
//   flit_t                              : flit type at the default width
package noc_pkg;

    localparam int unsigned NOC_DATA_W = 16;
    localparam int unsigned NOC_DEPTH  = 4;
    localparam int unsigned NOC_NUM_VC = 2;

    typedef logic [NOC_DATA_W-1:0] flit_t;

endpackage

// File: rtl/noc_rr_arbiter.sv
// noc_rr_arbiter: round-robin selector over NUM_VC request lines.
//   clk, rst        : clock, synchronous active-high reset
//   i_req           : per-VC request (VC non-empty)
//   i_advance       : a grant was consumed this cycle; remember it as last grant
//   o_grant         : granted VC index (0 when nothing requested)
//   o_grant_valid   : at least one request present
// The search starts one past the last consumed grant, so the grant only
// moves on a consumed grant or when a higher-priority VC starts requesting.
module noc_rr_arbiter
    import noc_pkg::*;
#(
    parameter int unsigned NUM_VC = NOC_NUM_VC
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_VC-1:0]         i_req,
    input  logic                      i_advance,
    output logic [$clog2(NUM_VC)-1:0] o_grant,
    output logic                      o_grant_valid
);

    localparam int unsigned VC_W = $clog2(NUM_VC);

    logic [VC_W-1:0] r_last_grant;

    always_comb begin
        o_grant       = '0;
        o_grant_valid = 1'b0;
        for (int unsigned i = 1; i <= NUM_VC; i++) begin
            if (!o_grant_valid && i_req[(32'(r_last_grant) + i) % NUM_VC]) begin
                o_grant       = VC_W'((32'(r_last_grant) + i) % NUM_VC);
                o_grant_valid = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= VC_W'(NUM_VC - 1);
        end else if (i_advance && o_grant_valid) begin
            r_last_grant <= o_grant;
        end
    end

endmodule

// File: rtl/noc_vc_input_port.sv
// noc_vc_input_port: NoC router input port with one circular FIFO per virtual
// channel, round-robin output selection and one-cycle credit return.
//   clk, rst      : clock, synchronous active-high reset
//   data_i, vc_i  : incoming flit and its target VC
//   write_en_i    : write request (dropped if the target VC is full)
//   ready_i       : downstream accepts data_o/vc_o this cycle
//   data_o, vc_o  : head flit of the granted VC and that VC (0 when idle)
//   valid_o       : some VC holds a flit
//   credit_o      : pulse the cycle after each pop, credit_vc_o = popped VC
//   full_o        : per-VC full flags
// Optional (macro NOC_INPORT_ERR_STATUS_EN):
//   overflow_o    : sticky, a write was dropped
//   underflow_o   : sticky, ready_i was high with nothing valid
module noc_vc_input_port
    import noc_pkg::*;
#(
    parameter int unsigned DATA_W = NOC_DATA_W,
    parameter int unsigned DEPTH  = NOC_DEPTH,
    parameter int unsigned NUM_VC = NOC_NUM_VC
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_W-1:0]         data_i,
    input  logic [$clog2(NUM_VC)-1:0] vc_i,
    input  logic                      write_en_i,
    input  logic                      ready_i,
    output logic [DATA_W-1:0]         data_o,
    output logic [$clog2(NUM_VC)-1:0] vc_o,
    output logic                      valid_o,
    output logic                      credit_o,
    output logic [$clog2(NUM_VC)-1:0] credit_vc_o,
    output logic [NUM_VC-1:0]         full_o
`ifdef NOC_INPORT_ERR_STATUS_EN
    ,
    output logic                      overflow_o,
    output logic                      underflow_o
`endif
);

    localparam int unsigned VC_W  = $clog2(NUM_VC);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] r_mem    [NUM_VC][DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr [NUM_VC];
    logic [PTR_W-1:0]  r_rd_ptr [NUM_VC];
    logic [CNT_W-1:0]  r_count  [NUM_VC];
    logic              r_credit;
    logic [VC_W-1:0]   r_credit_vc;

    logic [NUM_VC-1:0] w_req;
    logic [NUM_VC-1:0] w_wr_vec;
    logic [NUM_VC-1:0] w_rd_vec;
    logic [VC_W-1:0]   w_grant;
    logic              w_valid;
    logic              w_pop;
    logic              w_wr_ok;

    // Requests are masked during reset so nothing is presented or popped
    // while the FIFOs are being cleared.
    always_comb begin
        w_req = '0;
        for (int unsigned v = 0; v < NUM_VC; v++) begin
            w_req[v] = !rst && (r_count[v] != '0);
        end
    end

    noc_rr_arbiter #(
        .NUM_VC (NUM_VC)
    ) u_arb (
        .clk           (clk),
        .rst           (rst),
        .i_req         (w_req),
        .i_advance     (w_pop),
        .o_grant       (w_grant),
        .o_grant_valid (w_valid)
    );

    // Fullness is judged on the pre-pop count: a same-cycle pop does not
    // make room for a write into a full VC.
    always_comb begin
        w_pop    = w_valid && ready_i;
        w_wr_ok  = write_en_i && !rst && (32'(vc_i) < NUM_VC)
                   && (r_count[vc_i] != CNT_W'(DEPTH));
        w_wr_vec = '0;
        w_rd_vec = '0;
        for (int unsigned v = 0; v < NUM_VC; v++) begin
            w_wr_vec[v] = w_wr_ok && (vc_i == VC_W'(v));
            w_rd_vec[v] = w_pop && (w_grant == VC_W'(v));
        end
    end

    always_comb begin
        valid_o     = w_valid;
        data_o      = w_valid ? r_mem[w_grant][r_rd_ptr[w_grant]] : '0;
        vc_o        = w_valid ? w_grant : '0;
        credit_o    = r_credit;
        credit_vc_o = r_credit_vc;
        full_o      = '0;
        for (int unsigned v = 0; v < NUM_VC; v++) begin
            full_o[v] = !rst && (r_count[v] == CNT_W'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned v = 0; v < NUM_VC; v++) begin
            if (w_wr_vec[v]) begin
                r_mem[v][r_wr_ptr[v]] <= data_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned v = 0; v < NUM_VC; v++) begin
                r_wr_ptr[v] <= '0;
                r_rd_ptr[v] <= '0;
                r_count[v]  <= '0;
            end
        end else begin
            for (int unsigned v = 0; v < NUM_VC; v++) begin
                if (w_wr_vec[v]) begin
                    r_wr_ptr[v] <= r_wr_ptr[v] + PTR_W'(1);
                end
                if (w_rd_vec[v]) begin
                    r_rd_ptr[v] <= r_rd_ptr[v] + PTR_W'(1);
                end
                case ({w_wr_vec[v], w_rd_vec[v]})
                    2'b10:   r_count[v] <= r_count[v] + CNT_W'(1);
                    2'b01:   r_count[v] <= r_count[v] - CNT_W'(1);
                    default: r_count[v] <= r_count[v];
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_credit    <= 1'b0;
            r_credit_vc <= '0;
        end else begin
            r_credit    <= w_pop;
            r_credit_vc <= w_pop ? w_grant : '0;
        end
    end

`ifdef NOC_INPORT_ERR_STATUS_EN
    logic r_overflow;
    logic r_underflow;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (write_en_i && !w_wr_ok) begin
                r_overflow <= 1'b1;
            end
            if (ready_i && !w_valid) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign overflow_o  = r_overflow;
    assign underflow_o = r_underflow;
`endif

endmodule
